// File: rtl/palindrome_frame_rx.sv
// Serial frame receiver: start bit, 8 data bits MSB first, optional even parity, stop bit.
// Define PAL_RX_PARITY_CHECK_EN to insert and check the parity bit before the stop bit.
`timescale 1ns/1ps
module palindrome_frame_rx #(
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       bit_in,
  input  logic       bit_valid,
  output logic [7:0] num,
  output logic       num_valid,
  input  logic       num_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int IW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DATA   = 3'd1,
    S_STOP   = 3'd2,
`ifdef PAL_RX_PARITY_CHECK_EN
    S_PARITY = 3'd4,
`endif
    S_HOLD   = 3'd3
  } state_t;

  state_t          state_q;
  logic [7:0]      shift_q;
  logic [2:0]      bit_cnt_q;
  logic [IW-1:0]   idle_cnt_q;
  logic [7:0]      num_q;
  logic            num_valid_q;
  logic            frame_err_q;
  logic            overrun_q;

  logic [7:0]      shift_d;
  logic            in_frame;

  assign shift_d  = {shift_q[6:0], bit_in};
`ifdef PAL_RX_PARITY_CHECK_EN
  assign in_frame = (state_q == S_DATA) || (state_q == S_PARITY) || (state_q == S_STOP);
`else
  assign in_frame = (state_q == S_DATA) || (state_q == S_STOP);
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      shift_q     <= 8'h00;
      bit_cnt_q   <= 3'd0;
      idle_cnt_q  <= '0;
      num_q       <= 8'h00;
      num_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (bit_valid && bit_in) begin
            state_q    <= S_DATA;
            bit_cnt_q  <= 3'd0;
            shift_q    <= 8'h00;
            idle_cnt_q <= '0;
          end
        end
        S_DATA: begin
          if (bit_valid) begin
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_q + 3'd1;
            idle_cnt_q <= '0;
            if (bit_cnt_q == 3'd7) begin
`ifdef PAL_RX_PARITY_CHECK_EN
              state_q <= S_PARITY;
`else
              state_q <= S_STOP;
`endif
            end
          end
        end
`ifdef PAL_RX_PARITY_CHECK_EN
        S_PARITY: begin
          if (bit_valid) begin
            idle_cnt_q <= '0;
            if ((^shift_q) == bit_in) begin
              state_q <= S_STOP;
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= S_IDLE;
            end
          end
        end
`endif
        S_STOP: begin
          if (bit_valid) begin
            idle_cnt_q <= '0;
            if (!bit_in) begin
              num_q       <= shift_q;
              num_valid_q <= 1'b1;
              state_q     <= S_HOLD;
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= S_IDLE;
            end
          end
        end
        S_HOLD: begin
          // Bits arriving while a word waits are dropped; a start bit flags the loss.
          if (bit_valid && bit_in) overrun_q <= 1'b1;
          if (num_ready) begin
            num_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase

      if (in_frame && !bit_valid) begin
        if (idle_cnt_q == IW'(TIMEOUT - 1)) begin
          frame_err_q <= 1'b1;
          state_q     <= S_IDLE;
          idle_cnt_q  <= '0;
        end else begin
          idle_cnt_q <= idle_cnt_q + 1'b1;
        end
      end
    end
  end

  assign num       = num_q;
  assign num_valid = num_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_palindrome_frame_rx.sv
// Self-checking bench for palindrome_frame_rx: vector table, hand-written corner
// sequences and a scoreboard of expected accepted words.
`timescale 1ns/1ps
module tb_palindrome_frame_rx;

  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       bit_in = 1'b0;
  logic       bit_valid = 1'b0;
  logic [7:0] num;
  logic       num_valid;
  logic       num_ready = 1'b0;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int n_checks = 0;
  int n_fail = 0;

  logic [7:0] exp_q[$];
  logic [7:0] exp_w;
  logic [7:0] last_num;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         ready_delay;
    logic       exp_ok;
  } vec_t;

  vec_t vecs[6];

  palindrome_frame_rx #(.TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
    .num       (num),
    .num_valid (num_valid),
    .num_ready (num_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    bit_valid = 1'b1;
    bit_in    = b;
    tick();
    bit_valid = 1'b0;
    bit_in    = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_flip);
    drive_bit(1'b1);
    for (int i = 7; i >= 0; i--) drive_bit(d[i]);
`ifdef PAL_RX_PARITY_CHECK_EN
    drive_bit((^d) ^ par_flip);
`else
    if (par_flip) $display("note: parity flip ignored without parity build");
`endif
    drive_bit(stop);
  endtask

  // Scoreboard: every handshake must match the oldest expected word.
  always @(negedge clk) begin
    if (rst_n && num_valid && num_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_unexpected: got num %h with no word expected at %0t", num, $time);
      end else begin
        exp_w = exp_q.pop_front();
        check8("sb_num", num, exp_w);
        $display("accepted num=%h expected=%h", num, exp_w);
      end
    end
  end

  initial begin
    vecs[0] = '{8'h5A, 1'b0, 0, 1'b1};
    vecs[1] = '{8'hCA, 1'b0, 5, 1'b1};
    vecs[2] = '{8'h08, 1'b1, 0, 1'b0};
    vecs[3] = '{8'hFF, 1'b0, 2, 1'b1};
    vecs[4] = '{8'h81, 1'b1, 3, 1'b0};
    vecs[5] = '{8'h00, 1'b0, 1, 1'b1};
    last_num = 8'h00;

    rst_n = 1'b0;
    tick();
    tick();
    check8("rst_num", num, 8'h00);
    check1("rst_valid", num_valid, 1'b0);
    check1("rst_ferr", frame_err, 1'b0);
    check1("rst_overrun", overrun, 1'b0);
    check1("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    tick();

    for (int v = 0; v < 6; v++) begin
      num_ready = (vecs[v].ready_delay == 0);
      if (vecs[v].exp_ok) exp_q.push_back(vecs[v].data);
      send_frame(vecs[v].data, vecs[v].stop, 1'b0);
      $display("frame %0d data=%h stop=%b valid=%b ferr=%b", v, vecs[v].data, vecs[v].stop, num_valid, frame_err);
      check1("stop_valid", num_valid, vecs[v].exp_ok);
      check1("stop_ferr", frame_err, !vecs[v].exp_ok);
      if (vecs[v].exp_ok) begin
        check8("hold_num", num, vecs[v].data);
        for (int k = 0; k < vecs[v].ready_delay; k++) begin
          tick();
          check1("hold_valid", num_valid, 1'b1);
          check8("hold_stable", num, vecs[v].data);
        end
        num_ready = 1'b1;
        tick();
        check1("accept_valid_clr", num_valid, 1'b0);
        check1("accept_busy", busy, 1'b0);
        last_num = vecs[v].data;
      end else begin
        check8("err_num_kept", num, last_num);
        tick();
        check1("err_pulse_end", frame_err, 1'b0);
        check1("err_busy", busy, 1'b0);
      end
      num_ready = 1'b0;
      tick();
    end

    // Abort followed immediately by a new start bit.
    num_ready = 1'b1;
    send_frame(8'h81, 1'b1, 1'b0);
    check1("b2b_ferr", frame_err, 1'b1);
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b0, 1'b0);
    $display("b2b frame num=%h valid=%b", num, num_valid);
    check1("b2b_valid", num_valid, 1'b1);
    check8("b2b_num", num, 8'h3C);
    tick();
    check1("b2b_valid_clr", num_valid, 1'b0);
    last_num = 8'h3C;
    num_ready = 1'b0;

    // Timeout: idle counter restarts on each bit, aborts on the TO-th idle cycle.
    drive_bit(1'b1);
    drive_bit(1'b1);
    drive_bit(1'b0);
    repeat (TO - 1) tick();
    check1("to_busy_a", busy, 1'b1);
    check1("to_ferr_a", frame_err, 1'b0);
    drive_bit(1'b1);
    repeat (TO - 1) tick();
    check1("to_busy_b", busy, 1'b1);
    check1("to_ferr_b", frame_err, 1'b0);
    tick();
    $display("timeout ferr=%b busy=%b", frame_err, busy);
    check1("to_ferr", frame_err, 1'b1);
    check1("to_busy_clr", busy, 1'b0);
    tick();
    check1("to_ferr_end", frame_err, 1'b0);

`ifdef PAL_RX_PARITY_CHECK_EN
    drive_bit(1'b1);
    for (int i = 7; i >= 0; i--) drive_bit(vecs[2].data[i]);
    drive_bit(1'b0);
    $display("parity frame ferr=%b valid=%b", frame_err, num_valid);
    check1("par_ferr", frame_err, 1'b1);
    check1("par_valid", num_valid, 1'b0);
    drive_bit(1'b0);
    check1("par_ferr_end", frame_err, 1'b0);
    check1("par_busy", busy, 1'b0);
`endif

    // Overrun while E7 waits, then reset discards it.
    send_frame(8'hE7, 1'b0, 1'b0);
    check1("ovr_valid", num_valid, 1'b1);
    check8("ovr_num", num, 8'hE7);
    check1("ovr_pre", overrun, 1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    $display("overrun=%b num=%h", overrun, num);
    check1("ovr_set", overrun, 1'b1);
    check8("ovr_num_kept", num, 8'hE7);
    check1("ovr_valid_kept", num_valid, 1'b1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check8("rst2_num", num, 8'h00);
    check1("rst2_valid", num_valid, 1'b0);
    check1("rst2_ferr", frame_err, 1'b0);
    check1("rst2_overrun", overrun, 1'b0);
    check1("rst2_busy", busy, 1'b0);

    // Reset mid-frame: partial word dropped silently.
    drive_bit(1'b1);
    drive_bit(1'b1);
    drive_bit(1'b0);
    check1("mid_busy", busy, 1'b1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check1("mid_busy_clr", busy, 1'b0);
    check1("mid_ferr", frame_err, 1'b0);
    tick();
    check1("mid_ferr_after", frame_err, 1'b0);

    // num_ready with nothing pending, then a clean frame.
    num_ready = 1'b1;
    repeat (3) tick();
    check1("idle_ready_valid", num_valid, 1'b0);
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b0, 1'b0);
    check8("final_num", num, 8'hA5);
    check1("final_valid", num_valid, 1'b1);
    tick();
    num_ready = 1'b0;
    tick();

    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drained: got %0d words left expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
